// File: rtl/game_ctrl_if.sv
// Control/status bundle between the pong game-flow controller and the pixel/overlay logic.
interface game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       hit;
  logic       miss;
  logic       ball_run;
  logic       ball_reset;
  logic [7:0] score;
  logic [3:0] lives;
  logic [1:0] state;
  logic       game_over;

  modport slave (
    input  frame_tick, start, hit, miss,
    output ball_run, ball_reset, score, lives, state, game_over
  );

  modport master (
    output frame_tick, start, hit, miss,
    input  ball_run, ball_reset, score, lives, state, game_over
  );
endinterface

// File: rtl/game_ctrl.sv
// Pong game-flow FSM: IDLE -> SERVE -> PLAY -> OVER, all outputs registered (1-cycle response).
// Drives ball run/reset, BCD score and lives; only rising edges of start act.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 120
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  game_ctrl_if.slave  bus
);

  localparam int MAXF = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);
  localparam logic [CW-1:0] SERVE_C = CW'(SERVE_FRAMES);
  localparam logic [CW-1:0] OVER_C  = CW'(OVER_FRAMES);
  localparam logic [3:0]    LIVES_C = 4'(LIVES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [3:0]    lives_q, lives_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          brst_q, brst_d;
  logic          over_q, over_d;
  logic          start_q;

  logic          start_rise;
  logic [CW-1:0] cnt_inc;

  assign start_rise = bus.start & ~start_q;
  assign cnt_inc    = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      score_q <= 8'h00;
      lives_q <= LIVES_C;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      brst_q  <= 1'b0;
      over_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      brst_q  <= brst_d;
      over_q  <= over_d;
      start_q <= bus.start;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    run_d   = 1'b0;
    brst_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          score_d = 8'h00;
          lives_d = LIVES_C;
          cnt_d   = '0;
          brst_d  = ~brst_q;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_inc == SERVE_C) begin
            cnt_d   = '0;
            run_d   = 1'b1;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      PLAY: begin
        run_d = 1'b1;
        // A miss wins over a simultaneous hit.
        if (bus.miss) begin
          run_d  = 1'b0;
          brst_d = ~brst_q;
          cnt_d  = '0;
          if (lives_q <= 4'd1) begin
            lives_d = 4'd0;
            state_d = OVER;
          end else begin
            lives_d = lives_q - 1'b1;
            state_d = SERVE;
          end
        end else if (bus.hit) begin
          if (score_q == 8'h99) begin
            score_d = 8'h99;
          end else if (score_q[3:0] == 4'd9) begin
            score_d = {score_q[7:4] + 4'd1, 4'd0};
          end else begin
            score_d = {score_q[7:4], score_q[3:0] + 4'd1};
          end
        end
      end
      OVER: begin
        if (bus.frame_tick && (cnt_q < OVER_C)) begin
          cnt_d = cnt_inc;
        end
        // Edges arriving during the lockout are simply lost.
        if (start_rise && (cnt_q == OVER_C)) begin
          score_d = 8'h00;
          lives_d = LIVES_C;
          cnt_d   = '0;
          brst_d  = ~brst_q;
          state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase

    over_d = (state_d == OVER);
  end

  assign bus.ball_run   = run_q;
  assign bus.ball_reset = brst_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.state      = state_q;
  assign bus.game_over  = over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl (LIVES=2, SERVE_FRAMES=2, OVER_FRAMES=3) with an expectation queue.
module tb_game_ctrl;

  logic clk;
  logic rst_n;

  game_ctrl_if bus ();

  game_ctrl #(
    .LIVES       (2),
    .SERVE_FRAMES(2),
    .OVER_FRAMES (3)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [7:0] sc;
    logic [3:0] lv;
    logic       run;
    logic       br;
    logic       go;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string tag, input logic [1:0] st, input logic [7:0] sc,
                          input logic [3:0] lv, input logic run, input logic br);
    exp_t e;
    e.tag = tag; e.st = st; e.sc = sc; e.lv = lv; e.run = run; e.br = br;
    e.go  = (st == 2'b11);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty: got %0d entries, expected at least 1", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors += 5;
      assert (bus.state === e.st) else begin
        miscompares++; $error("FAIL %s.state: got %b expected %b", e.tag, bus.state, e.st);
      end
      assert (bus.score === e.sc) else begin
        miscompares++; $error("FAIL %s.score: got %h expected %h", e.tag, bus.score, e.sc);
      end
      assert (bus.lives === e.lv) else begin
        miscompares++; $error("FAIL %s.lives: got %0d expected %0d", e.tag, bus.lives, e.lv);
      end
      assert (bus.ball_run === e.run) else begin
        miscompares++; $error("FAIL %s.ball_run: got %b expected %b", e.tag, bus.ball_run, e.run);
      end
      assert (bus.ball_reset === e.br) else begin
        miscompares++; $error("FAIL %s.ball_reset: got %b expected %b", e.tag, bus.ball_reset, e.br);
      end
      vectors++;
      assert (bus.game_over === e.go) else begin
        miscompares++; $error("FAIL %s.game_over: got %b expected %b", e.tag, bus.game_over, e.go);
      end
    end
  endtask

  // Drive one cycle of inputs, then compare outputs 1 time unit after the edge.
  task automatic step(input string tag, input logic f, input logic s, input logic h, input logic m,
                      input logic [1:0] st, input logic [7:0] sc, input logic [3:0] lv,
                      input logic run, input logic br);
    bus.frame_tick = f;
    bus.start      = s;
    bus.hit        = h;
    bus.miss       = m;
    push_exp(tag, st, sc, lv, run, br);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [7:0] exp_sc;
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 2'b00, 8'h00, 4'd2, 1'b0, 1'b0);
    check_out();
    rst_n = 1'b1;
    step("idle", 0, 0, 0, 0, 2'b00, 8'h00, 4'd2, 0, 0);

    // 2: start, serve countdown, held start does not retrigger
    step("start",   0, 1, 0, 0, 2'b01, 8'h00, 4'd2, 0, 1);
    step("serve0",  0, 1, 0, 0, 2'b01, 8'h00, 4'd2, 0, 0);
    step("tick1",   1, 1, 0, 0, 2'b01, 8'h00, 4'd2, 0, 0);
    step("tick2",   1, 1, 0, 0, 2'b10, 8'h00, 4'd2, 1, 0);
    for (int i = 0; i < 50; i++)
      step("held", 0, 1, 0, 0, 2'b10, 8'h00, 4'd2, 1, 0);
    step("release", 0, 0, 0, 0, 2'b10, 8'h00, 4'd2, 1, 0);

    // 3: BCD scoring up to saturation; some hits coincide with frame ticks
    for (int i = 1; i <= 99; i++) begin
      exp_sc = 8'(((i / 10) << 4) | (i % 10));
      step((i == 11) ? "score11" : "hit", (i % 7 == 0), 0, 1, 0, 2'b10, exp_sc, 4'd2, 1, 0);
    end
    step("sat99", 0, 0, 1, 0, 2'b10, 8'h99, 4'd2, 1, 0);
    step("nohit", 1, 0, 0, 0, 2'b10, 8'h99, 4'd2, 1, 0);

    // 4: hit+miss together, then final miss into game over
    step("hitmiss",  0, 0, 1, 1, 2'b01, 8'h99, 4'd1, 0, 1);
    step("serve_b",  0, 0, 0, 0, 2'b01, 8'h99, 4'd1, 0, 0);
    step("tick1_b",  1, 0, 0, 0, 2'b01, 8'h99, 4'd1, 0, 0);
    step("tick2_b",  1, 0, 0, 0, 2'b10, 8'h99, 4'd1, 1, 0);
    step("lastmiss", 0, 0, 0, 1, 2'b11, 8'h99, 4'd0, 0, 1);
    step("over",     0, 0, 0, 0, 2'b11, 8'h99, 4'd0, 0, 0);

    // 5: start locked out until OVER_FRAMES ticks
    step("otick1",   1, 0, 0, 0, 2'b11, 8'h99, 4'd0, 0, 0);
    step("early",    0, 1, 0, 0, 2'b11, 8'h99, 4'd0, 0, 0);
    step("early_rl", 0, 0, 0, 0, 2'b11, 8'h99, 4'd0, 0, 0);
    step("otick2",   1, 0, 0, 0, 2'b11, 8'h99, 4'd0, 0, 0);
    step("otick3",   1, 0, 0, 0, 2'b11, 8'h99, 4'd0, 0, 0);
    step("restart",  0, 1, 0, 0, 2'b01, 8'h00, 4'd2, 0, 1);
    step("rst_rl",   0, 0, 0, 0, 2'b01, 8'h00, 4'd2, 0, 0);

    // 6: asynchronous reset in the middle of play
    step("tick1_c",  1, 0, 0, 0, 2'b01, 8'h00, 4'd2, 0, 0);
    step("tick2_c",  1, 0, 0, 0, 2'b10, 8'h00, 4'd2, 1, 0);
    for (int i = 1; i <= 5; i++)
      step("hit_c", 0, 0, 1, 0, 2'b10, 8'(i), 4'd2, 1, 0);
    step("play05", 0, 0, 0, 0, 2'b10, 8'h05, 4'd2, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_rst", 2'b00, 8'h00, 4'd2, 1'b0, 1'b0);
    check_out();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 2'b00, 8'h00, 4'd2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
